mem_initiator: RTL

Burst-capable initiator for the team's 8-bit single-port memory target. It accepts burst commands from a host on a valid/ready port and drives the target's rd_wr / rd_wr_valid / addr / wr_data signals one beat per cycle. Write data comes from a host stream. Read data captured from rd_data is returned through a 2-entry response buffer with backpressure. It sits between host logic and the memory target and is the only master of that target.

---
 rtl/mem_initiator_pkg.sv | 19 +
 rtl/mem_initiator_if.sv | 36 +++
 rtl/mem_initiator_rsp_fifo.sv | 58 +++++
 rtl/mem_initiator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_initiator_pkg.sv
// mem_init_pkg: shared types and constants for the mem_initiator slice.
//   state_t   : initiator FSM states
//   OP_READ / OP_WRITE : command opcode, same encoding as the target's rd_wr
//   RSP_DEPTH : read response buffer depth
package mem_init_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD       = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  localparam int unsigned RSP_DEPTH = 2;

endpackage

// File: rtl/mem_initiator_if.sv
// mem_initiator_if: bus between the initiator and the 8-bit single-port
// memory target.
//   rd_wr       : 1 = read, 0 = write
//   rd_wr_valid : beat strobe
//   addr        : beat address
//   wr_data     : write data
//   rd_data     : read data, valid in the cycle after a read beat, else 0
// Modports: master (initiator side), slave (target side).
interface mem_initiator_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  logic              rd_wr;
  logic              rd_wr_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_wr,
    output rd_wr_valid,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_wr,
    input  rd_wr_valid,
    input  addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/mem_initiator_rsp_fifo.sv
// mem_init_rsp_fifo: 2-entry synchronous FIFO holding read response beats.
//   clk, reset_n : clock, asynchronous active-low reset (flushes contents)
//   push, push_data : enqueue a beat
//   pop          : dequeue the head beat (ignored when empty)
//   count        : number of stored beats (0..2)
//   head         : oldest stored beat
module mem_init_rsp_fifo
  import mem_init_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] slot_q [RSP_DEPTH];
  logic              wr_idx_q;
  logic              rd_idx_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'(RSP_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        slot_q[wr_idx_q] <= push_data;
        wr_idx_q         <= ~wr_idx_q;
      end
      if (do_pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = slot_q[rd_idx_q];

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: burst initiator for the single-port memory target.
//   clk, reset_n   : clock, asynchronous active-low reset
//   req_*          : host burst command (valid/ready), op 1 = read, 0 = write,
//                    len = beats minus one
//   wdata_*        : host write-data stream (valid/ready)
//   rsp_*          : read-data stream to host via a 2-entry buffer
//   done / err     : one-cycle completion pulse / rejected-burst pulse
//   mem            : target bus (mem_initiator_if master)
// Build option: MEM_INIT_WRAP_EN - when defined, bursts wrap the address
// pointer at the top of memory; otherwise such bursts are rejected with err.
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  mem_initiator_if.master   mem
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              issue;
  logic              pop;
  logic              reject;
  logic              last_beat;
  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf_head;
  logic [2:0]        occupancy;
  logic              bus_rd_wr;
  logic [DATA_W-1:0] bus_wr_data;

`ifdef MEM_INIT_WRAP_EN
  assign reject = 1'b0;
`else
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, req_addr} + {1'b0, req_len};
  assign reject   = end_addr[ADDR_W];
`endif

  assign rsp_valid = (buf_count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign last_beat = (rem_q == (ADDR_W+1)'(1));
  // Buffered beats plus the one still on the bus, after this cycle's pop;
  // keeping this below 2 means the buffer always has room for rd_data.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    issue       = 1'b0;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    bus_rd_wr   = 1'b0;
    bus_wr_data = '0;
    case (state_q)
      IDLE: begin
        // Held off during the done cycle so a new command is taken only
        // once the previous completion has been signalled.
        req_ready = !done_q;
        if (req_valid && !done_q) begin
          ptr_d = req_addr;
          rem_d = {1'b0, req_len} + (ADDR_W+1)'(1);
          if (reject) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (req_op == OP_READ) begin
            state_d = RD;
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        wdata_ready = 1'b1;
        issue       = wdata_valid;
        if (issue) begin
          bus_wr_data = wdata;
          ptr_d       = ptr_q + ADDR_W'(1);
          rem_d       = rem_q - (ADDR_W+1)'(1);
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        bus_rd_wr = 1'b1;
        issue     = (rem_q != '0) && (occupancy < 3'd2);
        if (issue) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - (ADDR_W+1)'(1);
          if (last_beat) begin
            state_d = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (!inflight_q && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= issue && (state_q == RD);
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  mem_init_rsp_fifo #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (mem.rd_data),
    .pop       (pop),
    .count     (buf_count),
    .head      (buf_head)
  );

  assign rsp_data        = rsp_valid ? buf_head : '0;
  assign done            = done_q;
  assign err             = err_q;
  assign mem.rd_wr       = bus_rd_wr;
  assign mem.rd_wr_valid = issue;
  assign mem.addr        = ptr_q;
  assign mem.wr_data     = bus_wr_data;

endmodule
